spi_reg_ctrl: RTL

- Sequences the board's SPI slave shift core and turns its byte stream into a register-access protocol on the system clock.
- Synchronizes chip-select and byte-done events from the SPI core, decodes a command byte, then performs auto-incrementing register writes or reads.
- Preloads the SPI core's outgoing byte for each transfer.
- Register contents drive LEDs and other fabric logic through a flat output bus.

---
 rtl/spi_reg_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
// Register-access front end for the board's SPI slave shift core. Chip
// select and byte-done events from the SPI clock domain are brought onto
// clk. The first byte of a frame is a command: bit 7 selects write (1) or
// read (0), and bits 6:0 give the start address. Later bytes then write
// registers or read them back, with the address incrementing automatically.
// Address NREGS is a read-only status register; larger addresses are
// rejected for the rest of the frame.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   ce0_n        raw SPI chip select (active low, asynchronous)
//   rx_toggle    inverts once per received byte (asynchronous)
//   rx_data      last received byte, stable between toggles
//   status_in    value returned when reading address NREGS
//   tx_data      byte the SPI core shifts out on the next transfer
//   regs_flat    register file, reg i at bits [8i+7:8i]
//   wr_strobe    one-cycle pulse per register write
//   wr_addr      address of the write flagged by wr_strobe
//   frame_active high while a synchronized frame is in progress
//   err_pulse    one-cycle pulse when the command address is invalid
//   frame_count  number of completed frames, wraps 255 -> 0
module spi_reg_ctrl #(
  parameter int         NREGS     = 4,
  parameter logic [7:0] ID_BYTE   = 8'hA5,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter logic [7:0] ERR_BYTE  = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce0_n,
  input  logic                 rx_toggle,
  input  logic [7:0]           rx_data,
  input  logic [7:0]           status_in,
  output logic [7:0]           tx_data,
  output logic [NREGS*8-1:0]   regs_flat,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic                 frame_active,
  output logic                 err_pulse,
  output logic [7:0]           frame_count
);

  localparam logic [6:0] STAT_ADDR = 7'(NREGS);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DISCARD} state_t;

  state_t     state;
  logic [6:0] ptr;
  logic       got_byte;
  logic [7:0] regs [NREGS];
  logic [7:0] wr_data_p1;

  logic       cs_p0, cs_p1, cs_p2;
  logic       rt_p0, rt_p1, rt_p2;
  logic [2:0] sync_vld;
  logic       cs_start, cs_end, rx_evt;
  logic [6:0] cmd_addr;

  // Sync stages: p0/p1 resynchronize, p2 holds the previous value for edge
  // detection. sync_vld masks edges until p2 carries a real sample. Without
  // it, the reset value of the chip-select chain would look like a falling
  // edge whenever reset is released while ce0_n is already low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_p0    <= 1'b1;
      cs_p1    <= 1'b1;
      cs_p2    <= 1'b1;
      rt_p0    <= 1'b0;
      rt_p1    <= 1'b0;
      rt_p2    <= 1'b0;
      sync_vld <= 3'b000;
    end else begin
      cs_p0    <= ce0_n;
      cs_p1    <= cs_p0;
      cs_p2    <= cs_p1;
      rt_p0    <= rx_toggle;
      rt_p1    <= rt_p0;
      rt_p2    <= rt_p1;
      sync_vld <= {sync_vld[1:0], 1'b1};
    end
  end

  assign cs_start = sync_vld[2] &  cs_p2 & ~cs_p1;
  assign cs_end   = sync_vld[2] & ~cs_p2 &  cs_p1;
  assign rx_evt   = sync_vld[2] & (rt_p1 ^ rt_p2);
  assign cmd_addr = rx_data[6:0];

  function automatic logic [6:0] next_ptr(input logic [6:0] a);
    return (a == STAT_ADDR) ? 7'd0 : a + 7'd1;
  endfunction

  function automatic logic [7:0] rd_value(input logic [6:0] a);
    logic [7:0] v;
    v = status_in;
    for (int i = 0; i < NREGS; i++)
      if (a == 7'(i)) v = regs[i];
    return v;
  endfunction

  // Control FSM: the byte is handled first. A coincident cs_end then
  // overrides the state, and cs_start (re)opens a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 7'd0;
      got_byte     <= 1'b0;
      tx_data      <= ID_BYTE;
      wr_strobe    <= 1'b0;
      wr_addr      <= 7'd0;
      err_pulse    <= 1'b0;
      frame_active <= 1'b0;
      frame_count  <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        IDLE: ;
        CMD: if (rx_evt) begin
          if (cmd_addr > STAT_ADDR) begin
            state     <= DISCARD;
            tx_data   <= ERR_BYTE;
            err_pulse <= 1'b1;
          end else if (rx_data[7]) begin
            state <= WRITE;
            ptr   <= cmd_addr;
          end else begin
            state   <= READ;
            tx_data <= rd_value(cmd_addr);
            ptr     <= next_ptr(cmd_addr);
          end
        end
        WRITE: if (rx_evt) begin
          if (ptr != STAT_ADDR) begin
            wr_strobe <= 1'b1;
            wr_addr   <= ptr;
          end
          ptr      <= next_ptr(ptr);
          got_byte <= 1'b1;
        end
        READ: if (rx_evt) begin
          tx_data  <= rd_value(ptr);
          ptr      <= next_ptr(ptr);
          got_byte <= 1'b1;
        end
        DISCARD: ;
        default: state <= IDLE;
      endcase

      if (cs_end && state != IDLE) begin
        state        <= IDLE;
        frame_active <= 1'b0;
        tx_data      <= ID_BYTE;
        got_byte     <= 1'b0;
        if (state != DISCARD &&
            (got_byte || (rx_evt && (state == WRITE || state == READ))))
          frame_count <= frame_count + 8'd1;
      end

      if (cs_start) begin
        state        <= CMD;
        tx_data      <= ID_BYTE;
        frame_active <= 1'b1;
        got_byte     <= 1'b0;
      end
    end
  end

  // Write data stage: the received byte is captured alongside wr_strobe and
  // lands in the register file one cycle later.
  always_ff @(posedge clk) begin
    if (rx_evt) wr_data_p1 <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
    end else if (wr_strobe) begin
      for (int i = 0; i < NREGS; i++)
        if (wr_addr == 7'(i)) regs[i] <= wr_data_p1;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

endmodule
